// File: rtl/phy_tx_pkg.sv
// Shared constants for the multi-lane serial transmitter.
// Legal configuration ranges and the default idle symbol.
package phy_tx_pkg;

  localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;

  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 64;
  localparam int LANES_MIN  = 1;
  localparam int LANES_MAX  = 8;

  function automatic bit legal_cfg(int dw, int ln);
    return (dw >= DATA_W_MIN) && (dw <= DATA_W_MAX) &&
           (dw % 8 == 0) &&
           (ln >= LANES_MIN) && (ln <= LANES_MAX) &&
           ((ln & (ln - 1)) == 0);
  endfunction

endpackage

// File: rtl/phy_tx_lanes_lane.sv
// One lane: single-entry word buffer plus MSB-first shifter.
// Loads the buffered word (or idle) at each frame boundary.
module lane_serializer #(
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              load,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              bit_out,
  output logic              active
);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      word_q <= '0;
      full   <= 1'b0;
      sr     <= '0;
      active <= 1'b0;
    end else begin
      if (wr_en) begin
        word_q <= wr_data;
      end
      if (load) begin
        sr     <= full ? word_q : IDLE_WORD;
        active <= full;
      end else begin
        sr <= {sr[DATA_W-2:0], 1'b0};
      end
      // an empty lane may capture a word on its own load edge
      if (wr_en) begin
        full <= 1'b1;
      end else if (load) begin
        full <= 1'b0;
      end
    end
  end

  assign bit_out = sr[DATA_W-1];

endmodule

// File: rtl/phy_tx_lanes.sv
// Round-robin word distributor feeding LANES serializers
// that share one free-running bit counter / frame timebase.
module phy_tx_lanes
  import phy_tx_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         LANES    = 2,
  parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [LANES-1:0]  serial_out,
  output logic [LANES-1:0]  lane_active,
  output logic              frame_start
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] IDLE_WORD =
    {(DATA_W / 8){IDLE_SYM}};
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(LANES - 1);

  if (!legal_cfg(DATA_W, LANES)) begin : g_bad_cfg
    $error("phy_tx_lanes: illegal DATA_W/LANES");
  end

  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] full;
  logic             load;
  logic             xfer;

  assign load     = (cnt == '0);
  assign in_ready = ~full[ptr];
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr         <= '0;
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      frame_start <= load;
      if (xfer) begin
        ptr <= (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic wr_en;
    assign wr_en = xfer && (ptr == PW'(i));

    lane_serializer #(
      .DATA_W    (DATA_W),
      .IDLE_WORD (IDLE_WORD)
    ) u_lane (
      .clk     (clk),
      .reset_L (reset_L),
      .load    (load),
      .wr_en   (wr_en),
      .wr_data (in_data),
      .full    (full[i]),
      .bit_out (serial_out[i]),
      .active  (lane_active[i])
    );
  end

endmodule
